// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions.
//   arb_state_t         : memory arbiter FSM states
//   OWNER_IF / OWNER_D  : owner of the outstanding memory transaction
//   PC_PLUS_*           : PCSrc encodings; anything other than PC_PLUS_4
//                         flushes the fetch side of the memory arbiter
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;

  localparam logic [1:0] PC_PLUS_4    = 2'b00;
  localparam logic [1:0] PC_PLUS_IMM  = 2'b01;
  localparam logic [1:0] PC_PLUS_JADR = 2'b10;

endpackage

// File: rtl/mem_arbiter.sv
// Shares the unified instruction/data memory port between IF and MEM.
// One transaction in flight at a time; the response goes back to its owner
// as a one-cycle ready pulse. Fetches killed by a taken branch/jump still
// complete on the memory side but are swallowed (no if_ready).
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   if_req/if_addr/if_flush         fetch request, kill of pending fetch
//   if_ready/if_rdata               fetch response pulse / instruction
//   d_req/d_we/d_addr/d_wdata       load/store request
//   d_ready/d_rdata                 data response pulse / load data
//   mem_req/mem_we/mem_addr/mem_wdata  memory request (held until mem_gnt)
//   mem_gnt                         memory accepts request
//   mem_rvalid/mem_rdata            memory response, one per grant
// All outputs are registered.
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t state, state_nxt;
  logic       owner, last_owner, drop;
  logic       if_ok, d_ok, pick_d, issue, grant, resp, if_kill;

  // Next state and per-cycle events.
  always_comb begin
    // A requester whose ready pulses this cycle may still hold req; treat it
    // as already served so a late drop never re-issues.
    if_ok     = if_req & ~if_ready & ~if_flush;
    d_ok      = d_req & ~d_ready;
    // On a tie the port not served last wins.
    pick_d    = d_ok & (~if_ok | (last_owner == OWNER_IF));
    issue     = 1'b0;
    grant     = 1'b0;
    resp      = 1'b0;
    if_kill   = drop | if_flush;
    state_nxt = state;
    unique case (state)
      IDLE: if (if_ok || d_ok) begin
        issue     = 1'b1;
        state_nxt = REQ;
      end
      REQ: if (mem_gnt) begin
        grant     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: if (mem_rvalid) begin
        resp      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ready   <= 1'b0;
      d_ready    <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      drop       <= 1'b0;
      owner      <= OWNER_IF;
      last_owner <= OWNER_IF;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;

      if (issue) begin
        mem_req    <= 1'b1;
        owner      <= pick_d ? OWNER_D : OWNER_IF;
        last_owner <= pick_d ? OWNER_D : OWNER_IF;
        mem_we     <= pick_d & d_we;
        mem_addr   <= pick_d ? d_addr : if_addr;
        mem_wdata  <= pick_d ? d_wdata : '0;
      end

      if (grant) mem_req <= 1'b0;

      // The fetch in flight is stale; let it finish but forget the result.
      if (if_flush && owner == OWNER_IF && state != IDLE) drop <= 1'b1;

      if (resp) begin
        drop <= 1'b0;
        if (owner == OWNER_IF) begin
          if (!if_kill) begin
            if_ready <= 1'b1;
            if_rdata <= mem_rdata;
          end
        end else begin
          d_ready <= 1'b1;
          if (!mem_we) d_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios followed by a
// randomized phase with flushes, late req drops and random memory latency.
module tb_mem_arbiter;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        if_req = 1'b0, if_flush = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic        if_ready, d_ready, mem_req, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { bit we; logic [31:0] data; } d_exp_t;

  int          n_vec = 0, n_mis = 0;
  logic [31:0] if_q[$];
  d_exp_t      d_q[$];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Background memory contents: a hash of the address.
  function automatic logic [31:0] f(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic bit is_d_addr(logic [31:0] a);
    return (a >= 32'h100 && a < 32'h1000) || a >= 32'h2000;
  endfunction

  // ---------------- memory responder ----------------
  logic [31:0] mem_arr[logic [31:0]];
  int          gnt_wait = 0, rv_wait = 0, stray_cnt = 0;
  bit          rnd = 1'b0;
  int          hs_if = 0, hs_d = 0;
  logic [31:0] hs_addr[$];
  int          stray_seen = 0, gnt_cnt = 0, rv_cnt = 0, cur_gnt = 0;
  bit          rv_pend = 1'b0;
  logic [31:0] rd;

  always begin
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    if (!rst_n) begin
      rv_pend = 1'b0;
      gnt_cnt = 0;
    end else if (stray_cnt != stray_seen) begin
      stray_seen = stray_cnt;
      mem_rvalid = 1'b1;
      mem_rdata = 32'hBAD0_BAD0;
    end else if (rv_pend) begin
      if (rv_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata = rd;
        rv_pend = 1'b0;
      end else rv_cnt--;
    end else if (mem_req) begin
      cur_gnt = rnd ? int'($urandom_range(0, 3)) : gnt_wait;
      if (gnt_cnt >= cur_gnt) begin
        mem_gnt = 1'b1;
        hs_addr.push_back(mem_addr);
        if (is_d_addr(mem_addr)) hs_d++; else hs_if++;
        if (mem_we) mem_arr[mem_addr] = mem_wdata;
        else rd = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : f(mem_addr);
        rv_pend = 1'b1;
        rv_cnt = rnd ? int'($urandom_range(0, 2)) : rv_wait;
        gnt_cnt = 0;
      end else gnt_cnt++;
    end
  end

  // ---------------- response monitor ----------------
  logic   prev_if_rdy = 1'b0, prev_d_rdy = 1'b0;
  d_exp_t de;

  always begin
    @(posedge clk); #1;
    if (if_ready) begin
      chk("if_ready_pulse_width", 32'(prev_if_rdy), 32'd0);
      if (if_q.size() == 0) chk("if_spurious_ready", 32'(if_ready), 32'd0);
      else chk("if_rdata", if_rdata, if_q.pop_front());
    end
    if (d_ready) begin
      chk("d_ready_pulse_width", 32'(prev_d_rdy), 32'd0);
      if (d_q.size() == 0) chk("d_spurious_ready", 32'(d_ready), 32'd0);
      else begin
        de = d_q.pop_front();
        if (!de.we) chk("d_rdata", d_rdata, de.data);
      end
    end
    prev_if_rdy = if_ready;
    prev_d_rdy = d_ready;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic serve(input string nm, input int max);
    int n = 0;
    while ((if_req || d_req) && n < max) begin
      tick();
      n++;
      if (if_ready) if_req = 1'b0;
      if (d_ready) d_req = 1'b0;
    end
    if (if_req || d_req) begin
      chk({nm, "_timeout"}, {30'd0, if_req, d_req}, 32'd0);
      if_req = 1'b0;
      d_req = 1'b0;
    end
  endtask

  function automatic logic [31:0] hs_at(int i);
    return (i < hs_addr.size()) ? hs_addr[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic tie(input string nm, input logic [31:0] ia, input logic [31:0] da);
    int base = hs_addr.size();
    if_req = 1'b1; if_addr = ia; if_q.push_back(f(ia));
    d_req = 1'b1; d_we = 1'b0; d_addr = da; d_q.push_back('{1'b0, f(da)});
    serve(nm, 40);
    chk({nm, "_first_is_d"}, hs_at(base), da);
    chk({nm, "_second_is_if"}, hs_at(base + 1), ia);
  endtask

  logic [31:0] shadow[logic [31:0]];
  logic [31:0] last_if;
  int          if_st = 0, d_st = 0;
  bit          en;

  initial begin
    int n, base;
    bit saw, prev_rv;

    // Reset values
    tick(); tick();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_if_ready", 32'(if_ready), 32'd0);
    chk("rst_d_ready", 32'(d_ready), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // Fetch only, best-case latency
    mem_arr[32'h10] = 32'h0050_0093;
    mem_arr[32'h30] = 32'h1234_5678;
    gnt_wait = 0; rv_wait = 0;
    base = hs_if;
    if_req = 1'b1; if_addr = 32'h10; if_q.push_back(32'h0050_0093);
    n = 0;
    while (!if_ready && n < 10) begin tick(); n++; end
    chk("fetch_latency", n, 3);
    if_req = 1'b0;
    repeat (5) tick();
    chk("fetch_one_handshake", hs_if - base, 1);

    // Ties alternate via last_owner, data first out of reset
    tie("tie1", 32'h20, 32'h100);
    tie("tie2", 32'h24, 32'h104);
    last_if = f(32'h24);

    // Store with grant held off for 4 cycles
    gnt_wait = 4;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
    d_q.push_back('{1'b1, 32'h0});
    n = 0;
    while (!mem_req && n < 5) begin tick(); n++; end
    for (int i = 0; i < 4; i++) begin
      chk("store_mem_req_held", 32'(mem_req), 32'd1);
      chk("store_mem_we", 32'(mem_we), 32'd1);
      chk("store_mem_addr", mem_addr, 32'h200);
      chk("store_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      if (i < 3) tick();
    end
    prev_rv = 1'b0; n = 0;
    while (d_req && n < 20) begin
      tick(); n++;
      if (d_ready) begin
        chk("store_ready_after_rvalid", 32'(prev_rv), 32'd1);
        d_req = 1'b0;
      end
      prev_rv = mem_rvalid;
    end
    chk("store_done", 32'(d_req), 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    shadow[32'h200] = 32'hDEAD_BEEF;
    gnt_wait = 0;
    d_req = 1'b1; d_addr = 32'h200; d_q.push_back('{1'b0, 32'hDEAD_BEEF});
    serve("load_back", 20);

    // Flush during an IF WAIT swallows the response
    rv_wait = 2;
    base = hs_if;
    if_req = 1'b1; if_addr = 32'h30;
    n = 0;
    while (hs_if == base && n < 10) begin tick(); n++; end
    tick();
    if_flush = 1'b1; if_req = 1'b0;
    tick();
    if_flush = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin saw |= if_ready; tick(); end
    chk("flush_no_if_ready", 32'(saw), 32'd0);
    chk("flush_if_rdata_held", if_rdata, last_if);
    rv_wait = 0;
    if_req = 1'b1; if_addr = 32'h40; if_q.push_back(f(32'h40));
    serve("fetch_after_flush", 20);

    // Reset in REQ drops mem_req at once; stray rvalid afterwards ignored
    gnt_wait = 3;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104; d_q.push_back('{1'b0, f(32'h104)});
    n = 0;
    while (!mem_req && n < 5) begin tick(); n++; end
    chk("pre_reset_mem_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0; d_req = 1'b0; void'(d_q.pop_back());
    #1;
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    gnt_wait = 0;
    tick();
    stray_cnt++;
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); saw |= if_ready | d_ready | mem_req; end
    chk("stray_rvalid_ignored", 32'(saw), 32'd0);
    tie("tie_after_reset", 32'h28, 32'h108);

    // Requester drops d_req one cycle late
    base = hs_d;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10C; d_q.push_back('{1'b0, f(32'h10C)});
    n = 0;
    while (!d_ready && n < 20) begin tick(); n++; end
    tick();
    d_req = 1'b0;
    repeat (6) tick();
    chk("late_drop_one_handshake", hs_d - base, 1);

    // Randomized phase
    rnd = 1'b1;
    en = 1'b1;
    for (int cyc = 0; cyc < 3300; cyc++) begin
      if (cyc == 3000) en = 1'b0;
      tick();
      if_flush = 1'b0;
      case (if_st)
        1: if (if_ready) begin
             if ($urandom_range(0, 3) == 0) if_st = 2;
             else begin if_req = 1'b0; if_st = 0; end
           end else if ($urandom_range(0, 15) == 0) begin
             if_flush = 1'b1;
             void'(if_q.pop_back());
             if_st = 2;
           end
        2: begin if_req = 1'b0; if_st = 0; end
        default: begin
          if ($urandom_range(0, 19) == 0) if_flush = 1'b1;
          else if (en && $urandom_range(0, 2) == 0) begin
            if_addr = 32'h1000 + 4 * $urandom_range(0, 1023);
            if_q.push_back(f(if_addr));
            if_req = 1'b1;
            if_st = 1;
          end
        end
      endcase
      case (d_st)
        1: if (d_ready) begin
             if ($urandom_range(0, 3) == 0) d_st = 2;
             else begin d_req = 1'b0; d_st = 0; end
           end
        2: begin d_req = 1'b0; d_st = 0; end
        default: if (en && $urandom_range(0, 2) == 0) begin
          d_we = 1'($urandom_range(0, 1));
          d_addr = 32'h2000 + 4 * $urandom_range(0, 15);
          d_wdata = $urandom;
          if (d_we) begin
            shadow[d_addr] = d_wdata;
            d_q.push_back('{1'b1, 32'h0});
          end else
            d_q.push_back('{1'b0, shadow.exists(d_addr) ? shadow[d_addr] : f(d_addr)});
          d_req = 1'b1;
          d_st = 1;
        end
      endcase
    end
    if_flush = 1'b0;
    repeat (10) tick();
    chk("drain_if_state", if_st, 0);
    chk("drain_d_state", d_st, 0);
    chk("drain_if_q", if_q.size(), 0);
    chk("drain_d_q", d_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
